// File: rtl/gap_sched_pkg.sv
// rtl/gap_sched_pkg.sv - shared FSM state type and width helper for the GAP scheduler
package gap_sched_pkg;

    typedef enum logic [1:0] {
        eIDLE   = 2'd0,
        eSTREAM = 2'd1,
        eWAIT   = 2'd2
    } state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gap_arbiter.sv
// rtl/gap_arbiter.sv - combinational requester arbiter
// GAP_SCHED_RR_EN: round-robin from ptr_i; otherwise fixed priority, lowest index wins.
module gap_arbiter import gap_sched_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
`ifdef GAP_SCHED_RR_EN
    input  logic [ID_W-1:0]    ptr_i,
`endif
    output logic               any_o,
    output logic [ID_W-1:0]    grant_idx_o
);

`ifdef GAP_SCHED_RR_EN
    int k;

    // Scan offsets high to low so the nearest requester at or after ptr_i is assigned last.
    always_comb begin
        any_o       = |req_i;
        grant_idx_o = '0;
        k           = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = (int'(ptr_i) + i) % NUM_REQ;
            if (req_i[k]) begin
                grant_idx_o = ID_W'(k);
            end
        end
    end
`else
    always_comb begin
        any_o       = |req_i;
        grant_idx_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_idx_o = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/gap_scheduler.sv
// rtl/gap_scheduler.sv - shares one GAP datapath between NUM_REQ channel streams, one frame at a time
// GAP_SCHED_RR_EN selects round-robin arbitration with a priority pointer; default is fixed priority.
module gap_scheduler import gap_sched_pkg::*; #(
    parameter  int NUM_REQ    = 4,
    parameter  int INPUT_SIZE = 8,
    parameter  int WORD_SIZE  = 16,
    localparam int ID_W       = id_width(NUM_REQ)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [NUM_REQ-1:0]           valid_i,
    output logic [NUM_REQ-1:0]           ready_o,
    input  logic [NUM_REQ*WORD_SIZE-1:0] data_i,
    output logic                         gap_valid_o,
    input  logic                         gap_ready_i,
    output logic [WORD_SIZE-1:0]         gap_data_o,
    input  logic                         gap_valid_i,
    output logic                         gap_ready_o,
    input  logic [WORD_SIZE-1:0]         gap_data_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [WORD_SIZE-1:0]         data_o,
    output logic [ID_W-1:0]              id_o
);

    localparam int               CNT_W = id_width(INPUT_SIZE);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(INPUT_SIZE - 1);

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        grant_q, grant_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   arb_any;
    logic [ID_W-1:0]        arb_idx;
    logic                   gnt_valid;
    logic [WORD_SIZE-1:0]   gnt_data;
    logic                   word_hs;
    logic                   result_hs;

`ifdef GAP_SCHED_RR_EN
    logic [ID_W-1:0]        ptr_q, ptr_d;

    gap_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arbiter (
        .req_i       (valid_i),
        .ptr_i       (ptr_q),
        .any_o       (arb_any),
        .grant_idx_o (arb_idx)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (result_hs) begin
            ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    gap_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arbiter (
        .req_i       (valid_i),
        .any_o       (arb_any),
        .grant_idx_o (arb_idx)
    );
`endif

    // Compare-based lane select keeps index widths exact for any NUM_REQ.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q == ID_W'(k)) begin
                gnt_valid = valid_i[k];
                gnt_data  = data_i[k*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign word_hs   = (state_q == eSTREAM) && gnt_valid && gap_ready_i;
    assign result_hs = (state_q == eWAIT) && gap_valid_i && ready_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= eIDLE;
            grant_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        count_d = count_q;
        case (state_q)
            eIDLE: begin
                if (arb_any) begin
                    grant_d = arb_idx;
                    count_d = '0;
                    state_d = eSTREAM;
                end
            end
            eSTREAM: begin
                if (word_hs) begin
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = eWAIT;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            eWAIT: begin
                if (result_hs) begin
                    state_d = eIDLE;
                end
            end
            default: state_d = eIDLE;
        endcase
    end

    always_comb begin
        ready_o     = '0;
        gap_valid_o = 1'b0;
        gap_data_o  = '0;
        gap_ready_o = 1'b0;
        valid_o     = 1'b0;
        data_o      = '0;
        id_o        = '0;
        case (state_q)
            eSTREAM: begin
                gap_valid_o = gnt_valid;
                gap_data_o  = gnt_data;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (grant_q == ID_W'(k)) begin
                        ready_o[k] = gap_ready_i;
                    end
                end
            end
            eWAIT: begin
                valid_o     = gap_valid_i;
                data_o      = gap_data_i;
                id_o        = grant_q;
                gap_ready_o = ready_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gap_scheduler.sv
// tb/tb_gap_scheduler.sv - self-checking bench for gap_scheduler with a frame-level reference model
module tb_gap_scheduler;
    import gap_sched_pkg::*;

    localparam int NR  = 4;
    localparam int IS  = 4;
    localparam int W   = 16;
    localparam int IDW = id_width(NR);

    logic clk = 1'b0;
    logic reset_n;
    logic [NR-1:0]   valid_i, ready_o;
    logic [NR*W-1:0] data_i;
    logic            gap_valid_o, gap_ready_i, gap_valid_i, gap_ready_o, valid_o, ready_i;
    logic [W-1:0]    gap_data_o, gap_data_i, data_o;
    logic [IDW-1:0]  id_o;

    logic            s_valid_i, s_ready_o, s_gap_valid_o, s_gap_ready_i, s_gap_valid_i;
    logic            s_gap_ready_o, s_valid_o, s_ready_i;
    logic [W-1:0]    s_data_i, s_gap_data_o, s_gap_data_i, s_data_o;
    logic [0:0]      s_id_o;

    always #5 clk = ~clk;

    gap_scheduler #(.NUM_REQ(NR), .INPUT_SIZE(IS), .WORD_SIZE(W)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .gap_valid_o(gap_valid_o), .gap_ready_i(gap_ready_i), .gap_data_o(gap_data_o),
        .gap_valid_i(gap_valid_i), .gap_ready_o(gap_ready_o), .gap_data_i(gap_data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .id_o(id_o)
    );

    gap_scheduler #(.NUM_REQ(1), .INPUT_SIZE(1), .WORD_SIZE(W)) dut_single (
        .clk_i(clk), .reset_n_i(reset_n),
        .valid_i(s_valid_i), .ready_o(s_ready_o), .data_i(s_data_i),
        .gap_valid_o(s_gap_valid_o), .gap_ready_i(s_gap_ready_i), .gap_data_o(s_gap_data_o),
        .gap_valid_i(s_gap_valid_i), .gap_ready_o(s_gap_ready_o), .gap_data_i(s_gap_data_i),
        .valid_o(s_valid_o), .ready_i(s_ready_i), .data_o(s_data_o), .id_o(s_id_o)
    );

    // Frame-level model: who owns the datapath, how many words it delivered, result pending.
    int       owner = -1;
    int       sent = 0;
    int       ptr = 0;
    int       sum = 0;
    bit       waiting = 1'b0;
    logic [W-1:0] res = '0;
    int       dut_ids[$];
    int       exp_ids[5];
    int       n_cmp = 0;
    int       n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int arb(input logic [NR-1:0] v);
`ifdef GAP_SCHED_RR_EN
        for (int i = 0; i < NR; i++) if (v[(ptr + i) % NR]) return (ptr + i) % NR;
`else
        for (int i = 0; i < NR; i++) if (v[i]) return i;
`endif
        return -1;
    endfunction

    task automatic check_outputs();
        logic [NR-1:0]  e_rdy = '0;
        logic           e_gv = 1'b0, e_v = 1'b0, e_gr = 1'b0;
        logic [W-1:0]   e_gd = '0, e_d = '0;
        logic [IDW-1:0] e_id = '0;
        if (owner >= 0 && !waiting) begin
            e_gv = valid_i[owner];
            e_gd = data_i[owner*W +: W];
            if (gap_ready_i) e_rdy[owner] = 1'b1;
        end
        if (waiting) begin
            e_v  = gap_valid_i;
            e_d  = gap_data_i;
            e_id = IDW'(owner);
            e_gr = ready_i;
        end
        chk("ready_o", ready_o, e_rdy);
        chk("gap_valid_o", gap_valid_o, e_gv);
        chk("gap_data_o", gap_data_o, e_gd);
        chk("gap_ready_o", gap_ready_o, e_gr);
        chk("valid_o", valid_o, e_v);
        chk("data_o", data_o, e_d);
        chk("id_o", id_o, e_id);
        if (waiting && gap_valid_i && ready_i) begin
            chk("result_avg", data_o, res);
            dut_ids.push_back(int'(id_o));
        end
    endtask

    task automatic update();
        if (!reset_n) begin
            owner = -1; sent = 0; waiting = 1'b0; ptr = 0; sum = 0;
        end else if (owner < 0) begin
            owner = arb(valid_i); sent = 0; sum = 0;
        end else if (!waiting) begin
            if (valid_i[owner] && gap_ready_i) begin
                sum += int'(data_i[owner*W +: W]);
                sent++;
                if (sent == IS) begin
                    waiting = 1'b1;
                    res = W'(sum / IS);
                end
            end
        end else if (gap_valid_i && ready_i) begin
            ptr = (owner + 1) % NR;
            owner = -1;
            waiting = 1'b0;
        end
    endtask

    task automatic cycle();
        #1 check_outputs();
        @(posedge clk);
        update();
        @(negedge clk);
    endtask

    task automatic drive_gap(input bit gv);
        gap_valid_i = gv;
        gap_data_i  = waiting ? res : W'($urandom);
    endtask

    task automatic set_word(input int k, input logic [W-1:0] v);
        data_i[k*W +: W] = v;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; valid_i = '0; data_i = '0; gap_ready_i = 1'b0;
        gap_valid_i = 1'b0; gap_data_i = '0; ready_i = 1'b0;
        s_valid_i = 1'b0; s_data_i = '0; s_gap_ready_i = 1'b0;
        s_gap_valid_i = 1'b0; s_gap_data_i = '0; s_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        valid_i = '1; gap_valid_i = 1'b1; ready_i = 1'b1; gap_ready_i = 1'b1;
        #1;
        chk("rst_ready_o", ready_o, 0);
        chk("rst_gap_valid_o", gap_valid_o, 0);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_gap_ready_o", gap_ready_o, 0);
        valid_i = '0; gap_valid_i = 1'b0;
        reset_n = 1'b1;
        cycle();

        // Only requester 2: words 4, 8, 12, 16 average to 10.
        valid_i = 4'b0100; gap_ready_i = 1'b1; ready_i = 1'b1; drive_gap(1'b0);
        cycle();
        for (int i = 1; i <= 4; i++) begin
            set_word(2, W'(4 * i));
            cycle();
        end
        drive_gap(1'b1);
        #1;
        chk("t1_valid", valid_o, 1);
        chk("t1_data", data_o, 10);
        chk("t1_id", id_o, 2);
        cycle();
        valid_i = '0; drive_gap(1'b0);
        cycle();

        // Requester 1 stalls after word 2 while others request; then result held 5 cycles.
        valid_i = 4'b0010;
        cycle();
        for (int i = 0; i < 2; i++) begin set_word(1, W'($urandom)); cycle(); end
        valid_i = 4'b1101;
        repeat (3) cycle();
        #1 chk("stall_gap_valid", gap_valid_o, 0);
        valid_i = 4'b1111;
        for (int i = 0; i < 2; i++) begin set_word(1, W'($urandom)); cycle(); end
        ready_i = 1'b0; drive_gap(1'b1);
        repeat (5) begin
            #1;
            chk("hold_valid", valid_o, 1);
            chk("hold_data", data_o, res);
            chk("hold_id", id_o, 1);
            chk("hold_gap_ready", gap_ready_o, 0);
            chk("hold_no_grant", ready_o, 0);
            cycle();
        end
        ready_i = 1'b1;
        cycle();
        valid_i = '0; drive_gap(1'b0);
        cycle();

        // Reset after word 2 of a requester-3 frame, then a clean frame from requester 3.
        valid_i = 4'b1000;
        cycle();
        for (int i = 0; i < 2; i++) begin set_word(3, W'($urandom)); cycle(); end
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        #1;
        chk("mid_rst_gap_valid", gap_valid_o, 0);
        chk("mid_rst_ready", ready_o, 0);
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_id", id_o, 0);
        cycle();
        for (int i = 0; i < 4; i++) begin set_word(3, W'($urandom)); cycle(); end
        drive_gap(1'b1);
        #1 chk("post_rst_id", id_o, 3);
        cycle();
        valid_i = '0; drive_gap(1'b0);
        cycle();

        // All requesters continuously valid: order of result ids.
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        dut_ids.delete();
        valid_i = '1; gap_ready_i = 1'b1; ready_i = 1'b1;
        for (int c = 0; c < 60 && dut_ids.size() < 5; c++) begin
            data_i = {$urandom, $urandom};
            drive_gap(waiting);
            cycle();
        end
`ifdef GAP_SCHED_RR_EN
        exp_ids = '{0, 1, 2, 3, 0};
`else
        exp_ids = '{0, 0, 0, 0, 0};
`endif
        chk("order_count", dut_ids.size(), 5);
        for (int i = 0; i < dut_ids.size() && i < 5; i++) chk("order_id", dut_ids[i], exp_ids[i]);
        valid_i = '0; drive_gap(1'b0);
        cycle();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            reset_n     = ($urandom_range(0, 199) != 0);
            valid_i     = NR'($urandom);
            data_i      = {$urandom, $urandom};
            gap_ready_i = ($urandom_range(0, 3) != 0);
            ready_i     = ($urandom_range(0, 2) != 0);
            drive_gap(1'(($urandom_range(0, 1))));
            cycle();
        end
        reset_n = 1'b1; valid_i = '0;

        // Single requester, single-word frames.
        s_ready_i = 1'b1; s_gap_ready_i = 1'b1;
        for (int f = 0; f < 3; f++) begin
            s_valid_i = 1'b1; s_data_i = W'($urandom); s_gap_valid_i = 1'b0;
            @(posedge clk); @(negedge clk);
            #1;
            chk("s_gap_valid", s_gap_valid_o, 1);
            chk("s_gap_data", s_gap_data_o, s_data_i);
            chk("s_ready", s_ready_o, 1);
            chk("s_valid_early", s_valid_o, 0);
            @(posedge clk); @(negedge clk);
            s_valid_i = 1'b0; s_gap_valid_i = 1'b1; s_gap_data_i = W'(f + 100);
            #1;
            chk("s_valid", s_valid_o, 1);
            chk("s_data", s_data_o, W'(f + 100));
            chk("s_id", s_id_o, 0);
            chk("s_gap_ready", s_gap_ready_o, 1);
            chk("s_gap_valid_wait", s_gap_valid_o, 0);
            @(posedge clk); @(negedge clk);
            s_gap_valid_i = 1'b0;
            #1 chk("s_idle", s_valid_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
